// File: rtl/hls_macc_sched.sv
// hls_macc_sched: round-robin scheduler sharing one hls_macc core among NREQ requesters, one job at a time.
module hls_macc_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_i1,
    input  logic [32*NREQ-1:0]   req_i2,
    input  logic [32*NREQ-1:0]   req_i3,
    input  logic [32*NREQ-1:0]   req_i4,
    input  logic [32*NREQ-1:0]   req_i6,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          core_i1,
    output logic [31:0]          core_i2,
    output logic [31:0]          core_i3,
    output logic [31:0]          core_i4,
    output logic [31:0]          core_i6,
    output logic                 core_start,
    output logic                 core_rst,
    input  logic                 core_done,
    input  logic                 core_ready,
    input  logic [31:0]          core_o1,
    input  logic [31:0]          core_o2,
    input  logic                 core_o1_vld,
    input  logic                 core_o2_vld,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_o1,
    output logic [31:0]          rsp_o2,
    output logic [1:0]           rsp_err,
    output logic [15:0]          job_cnt,
    output logic [7:0]           err_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    state_t state_q, state_d;
    logic [1:0] last_q, gnt_idx;
    logic [7:0] cnt_q;
    logic seen1_q, seen2_q, grant, tmo, unused_ok;

    assign unused_ok  = core_ready;
    assign core_start = state_q == RUN;
    assign rsp_valid  = state_q == RESP;
    assign grant      = state_q == IDLE && |req_valid && !ap_rst;
    assign tmo        = cnt_q == 8'(TIMEOUT - 1);

    // descending scan so the nearest requester after last_q is the one left standing
    always_comb begin
        gnt_idx = last_q;
        for (int k = NREQ; k >= 1; k--)
            gnt_idx = req_valid[last_q + 2'(k)] ? last_q + 2'(k) : gnt_idx;
        req_ready = '0;
        req_ready[gnt_idx] = grant;
        state_d = grant ? RUN
                : (core_start && (core_done || tmo)) ? RESP
                : (rsp_valid && rsp_ready) ? IDLE : state_q;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            seen1_q  <= 1'b0;
            seen2_q  <= 1'b0;
            core_rst <= 1'b1;
            core_i1  <= '0;
            core_i2  <= '0;
            core_i3  <= '0;
            core_i4  <= '0;
            core_i6  <= '0;
            rsp_id   <= '0;
            rsp_o1   <= '0;
            rsp_o2   <= '0;
            rsp_err  <= '0;
            job_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            core_rst <= core_start && !core_done && tmo;
            if (grant) begin
                last_q  <= gnt_idx;
                rsp_id  <= gnt_idx;
                core_i1 <= req_i1[{gnt_idx, 5'd0} +: 32];
                core_i2 <= req_i2[{gnt_idx, 5'd0} +: 32];
                core_i3 <= req_i3[{gnt_idx, 5'd0} +: 32];
                core_i4 <= req_i4[{gnt_idx, 5'd0} +: 32];
                core_i6 <= req_i6[{gnt_idx, 5'd0} +: 32];
                cnt_q   <= '0;
                seen1_q <= 1'b0;
                seen2_q <= 1'b0;
                rsp_err <= '0;
                rsp_o1  <= '0;
                rsp_o2  <= '0;
            end
            if (core_start) begin
                cnt_q <= cnt_q + 8'd1;
                if (core_o1_vld) begin
                    rsp_o1  <= core_o1;
                    seen1_q <= 1'b1;
                end
                if (core_o2_vld) begin
                    rsp_o2  <= core_o2;
                    seen2_q <= 1'b1;
                end
                // done wins over a timeout landing in the same cycle
                if (core_done)
                    rsp_err <= {!(seen1_q || core_o1_vld) || !(seen2_q || core_o2_vld), 1'b0};
                else if (tmo) begin
                    rsp_err <= 2'b01;
                    rsp_o1  <= '0;
                    rsp_o2  <= '0;
                end
            end
            if (rsp_valid && rsp_ready) begin
                job_cnt <= job_cnt + 16'd1;
                if (|rsp_err && err_cnt != 8'hff)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_hls_macc_sched.sv
// tb_hls_macc_sched: directed checks of hls_macc_sched against a simple latency-programmable core model.
module tb_hls_macc_sched;
    logic         ap_clk = 1'b0, ap_rst = 1'b1;
    logic [3:0]   req_valid = '0, req_ready;
    logic [127:0] req_i1, req_i2, req_i3, req_i4, req_i6;
    logic [31:0]  core_i1, core_i2, core_i3, core_i4, core_i6;
    logic         core_start, core_rst, core_done, core_ready;
    logic [31:0]  core_o1, core_o2, rsp_o1, rsp_o2;
    logic         core_o1_vld, core_o2_vld, rsp_valid, rsp_ready = 1'b0;
    logic [1:0]   rsp_id, rsp_err;
    logic [15:0]  job_cnt;
    logic [7:0]   err_cnt;
    int n_chk = 0, n_err = 0;
    int core_cnt = 0, lat = 4;
    logic en_done = 1'b1, en_o2 = 1'b1, early = 1'b0;

    always #5 ap_clk = ~ap_clk;

    hls_macc_sched #(.NREQ(4), .TIMEOUT(8)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid),
        .req_i1(req_i1), .req_i2(req_i2), .req_i3(req_i3), .req_i4(req_i4), .req_i6(req_i6),
        .req_ready(req_ready), .core_i1(core_i1), .core_i2(core_i2), .core_i3(core_i3),
        .core_i4(core_i4), .core_i6(core_i6), .core_start(core_start), .core_rst(core_rst),
        .core_done(core_done), .core_ready(core_ready), .core_o1(core_o1), .core_o2(core_o2),
        .core_o1_vld(core_o1_vld), .core_o2_vld(core_o2_vld), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o1(rsp_o1), .rsp_o2(rsp_o2),
        .rsp_err(rsp_err), .job_cnt(job_cnt), .err_cnt(err_cnt));

    always @(posedge ap_clk) core_cnt <= core_start ? core_cnt + 1 : 0;
    assign core_done   = core_start && en_done && core_cnt == lat - 1;
    assign core_ready  = core_done;
    assign core_o1     = 32'h11;
    assign core_o2     = 32'h22;
    assign core_o1_vld = core_done || (core_start && early && core_cnt == 1);
    assign core_o2_vld = core_done && en_o2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // grant one requester, release its request and measure cycles until the response
    task automatic run_job(input string tag, input logic [3:0] rv, input int exp_lat, input logic exp_crst);
        int n;
        req_valid = rv;
        #1;
        check({tag, "_ready"}, req_ready, rv);
        tick;
        req_valid = '0;
        check({tag, "_start"}, core_start, 1'b1);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_crst"}, core_rst, exp_crst);
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] gv[5];
        int gc[5];
        int ng, c;
        logic [31:0] hold_o1;
        req_i1 = {32'hA3, 32'd5, 32'hA1, 32'hA0};
        req_i2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        req_i3 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        req_i4 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        req_i6 = {32'hE3, 32'h66, 32'hE1, 32'hE0};
        req_valid = 4'b1111;
        tick;
        tick;
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_start", core_start, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cnts", {job_cnt, err_cnt}, 24'h0);
        check("rst_core_i1", core_i1, 32'h0);
        req_valid = '0;
        ap_rst = 1'b0;
        tick;
        check("idle_noreq_ready", req_ready, 4'b0000);
        check("core_rst_release", core_rst, 1'b0);

        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        ng = 0;
        c = 0;
        while (ng < 5 && c < 60) begin
            if (|req_ready) begin
                gv[ng] = req_ready;
                gc[ng] = c;
                ng++;
            end
            if (ng < 5) begin
                tick;
                c++;
            end
        end
        check("rr_count", ng, 5);
        check("rr_g0", gv[0], 4'b0001);
        check("rr_g1", gv[1], 4'b0010);
        check("rr_g2", gv[2], 4'b0100);
        check("rr_g3", gv[3], 4'b1000);
        check("rr_g4", gv[4], 4'b0001);
        for (int i = 1; i < 5; i++) check("rr_period", gc[i] - gc[i-1], 6);
        tick;
        req_valid = '0;
        repeat (5) tick;
        check("rr_job_cnt", job_cnt, 16'd5);
        check("rr_idle", rsp_valid, 1'b0);
        rsp_ready = 1'b0;

        run_job("basic", 4'b0100, 5, 1'b0);
        check("basic_id", rsp_id, 2'd2);
        check("basic_o", {rsp_o1, rsp_o2}, {32'h11, 32'h22});
        check("basic_err", rsp_err, 2'b00);
        check("basic_core_i", {core_i1, core_i6}, {32'd5, 32'h66});
        hold_o1 = rsp_o1;
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_rsp", {rsp_id, rsp_o1, rsp_o2}, {2'd2, hold_o1, 32'h22});
            check("stall_ready", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        #1;
        check("stall_no_grant", req_ready, 4'b0000);
        tick;
        rsp_ready = 1'b0;
        check("basic_job_cnt", job_cnt, 16'd6);
        run_job("regrant", 4'b0001, 5, 1'b0);
        check("regrant_id", rsp_id, 2'd0);
        ack;

        en_done = 1'b0;
        early = 1'b1;
        run_job("tmo", 4'b0010, 9, 1'b1);
        check("tmo_err", rsp_err, 2'b01);
        check("tmo_o", {rsp_o1, rsp_o2}, 64'h0);
        tick;
        check("tmo_crst_pulse", core_rst, 1'b0);
        check("tmo_hold", rsp_valid, 1'b1);
        ack;
        check("tmo_err_cnt", err_cnt, 8'd1);
        en_done = 1'b1;
        early = 1'b0;

        lat = 8;
        run_job("prec", 4'b0010, 9, 1'b0);
        check("prec_err", rsp_err, 2'b00);
        check("prec_o1", rsp_o1, 32'h11);
        ack;
        lat = 4;

        en_o2 = 1'b0;
        run_job("novld", 4'b0100, 5, 1'b0);
        check("novld_err", rsp_err, 2'b10);
        check("novld_o", {rsp_o1, rsp_o2}, {32'h11, 32'h0});
        ack;
        check("novld_cnts", {job_cnt, err_cnt}, {16'd10, 8'd2});
        en_o2 = 1'b1;

        req_valid = 4'b1001;
        #1;
        check("mid_ready", req_ready, 4'b1000);
        tick;
        tick;
        check("mid_core_i1", core_i1, 32'hA3);
        ap_rst = 1'b1;
        tick;
        check("mid_rst_outs", {core_rst, core_start, rsp_valid, req_ready}, 7'b1000000);
        check("mid_rst_data", {core_i1, rsp_o1, rsp_id, rsp_err}, 68'h0);
        check("mid_rst_cnts", {job_cnt, err_cnt}, 24'h0);
        ap_rst = 1'b0;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hls_macc_sched.md
HLS_MACC_SCHED -- requirements
Module: hls_macc_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one hls_macc core (fixed at 4 in this revision).
REQ-002 Parameter TIMEOUT, default 255, maximum RUN cycles allowed before a job is aborted (1..255).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 ap_clk  in  1  clock; all state changes on the rising edge.
REQ-005 ap_rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  4  per-requester job request; held until the matching req_ready bit is seen.
REQ-007 req_i1, req_i2, req_i3, req_i4, req_i6  in  128 each  operands, requester k at bits [32k+31:32k].
REQ-008 req_ready  out  4  one-hot grant/accept pulse.
REQ-009 core_i1, core_i2, core_i3, core_i4, core_i6  out  32 each  latched operands driven to the core.
REQ-010 core_start  out  1  core ap_start.
REQ-011 core_rst  out  1  core ap_rst.
REQ-012 core_done, core_ready  in  1 each  core ap_done / ap_ready.
REQ-013 core_o1, core_o2  in  32 each  core results.
REQ-014 core_o1_vld, core_o2_vld  in  1 each  core result valid strobes.
REQ-015 rsp_valid  out  1  response handshake, valid side.
REQ-016 rsp_ready  in  1  response handshake, ready side.
REQ-017 rsp_id  out  2  requester index of the job.
REQ-018 rsp_o1, rsp_o2  out  32 each  captured results.
REQ-019 rsp_err  out  2  bit0 = timeout; bit1 = done without both valid strobes.
REQ-020 job_cnt  out  16  completed responses, wrapping.
REQ-021 err_cnt  out  8  responses with rsp_err != 0, saturating at 255.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, RUN, RESP.
REQ-023 IDLE behaviour:
- If any req_valid bit is set, the grant g is the first set bit after last_grant, searched round-robin modulo 4.
- req_ready[g] is asserted combinationally in the same cycle.
- All five operands of requester g are latched at that edge, with rsp_id <= g and last_grant <= g.
- The next state is RUN.
REQ-024 req_ready SHALL be zero outside IDLE and zero in IDLE when req_valid == 0.
REQ-025 core_start SHALL equal 1 exactly while the state is RUN.
REQ-026 core_i* SHALL hold the latched operands, unchanged, from grant until the next grant.
REQ-027 In RUN, rsp_o1 <= core_o1 on every cycle with core_o1_vld = 1, and rsp_o2 <= core_o2 on every cycle with core_o2_vld = 1; each sets its own seen-flag.
REQ-028 In RUN, core_done = 1 SHALL move the state to RESP.
- rsp_err[1] is set if either seen-flag is still 0, counting strobes that arrive in the done cycle itself.
- core_ready is ignored.
REQ-029 A RUN cycle counter SHALL start at 0 on entry to RUN.
- When it reaches TIMEOUT with no core_done: core_rst = 1 for the next cycle, rsp_err = 2'b01, rsp_o1 = rsp_o2 = 0, next state RESP.
- core_done in the same cycle as the timeout takes precedence over the timeout.
REQ-030 RESP behaviour:
- rsp_valid = 1 while in RESP, with rsp_* stable.
- On rsp_valid & rsp_ready: job_cnt increments; err_cnt increments if rsp_err != 0; next state IDLE.
REQ-031 Minimum job period SHALL be 6 cycles with a 4-cycle core: 1 IDLE + 4 RUN + 1 RESP.
REQ-032 The scheduler SHALL never have more than one job outstanding, and SHALL NOT grant in RESP.
REQ-033 Deasserting req_valid after the grant SHALL have no effect on the job in flight.
REQ-034 Seen-flags and rsp_err SHALL be cleared at every grant.

Reset
REQ-035 While ap_rst = 1, the scheduler SHALL hold every output listed below at its reset value:
- state = IDLE, last_grant = 3 (requester 0 first).
- core_rst = 1.
- core_start, req_ready, rsp_valid = 0.
- rsp_*, core_i*, job_cnt, err_cnt, counters, flags = 0.
REQ-036 Reset during RUN or RESP SHALL abandon the job with no response and no counter update.

Verification
REQ-037 req_valid = 4'b0100, req_i1[2] = 5, 4-cycle core model giving o1 = 0x11 and o2 = 0x22 with vld at done:
- req_ready = 4'b0100 in the first cycle; core_i1 = 5.
- rsp_valid appears 5 cycles after the grant with rsp_id = 2, rsp_o1 = 0x11, rsp_o2 = 0x22, rsp_err = 0; job_cnt = 1.
REQ-038 req_valid = 4'b1111 held, rsp_ready = 1: grants in order 0, 1, 2, 3, 0, each 6 cycles apart.
REQ-039 Core never asserts core_done, TIMEOUT = 8:
- RESP is reached after 8 RUN cycles with rsp_err = 2'b01 and rsp_o1 = rsp_o2 = 0.
- core_rst pulses for 1 cycle; err_cnt = 1.
REQ-040 core_done with core_o2_vld = 0 -> rsp_err = 2'b10, rsp_o1 captured, rsp_o2 = 0.
REQ-041 rsp_ready held 0 for 10 cycles:
- rsp_valid and rsp_* stay stable; no new req_ready.
- The IDLE grant follows one cycle after rsp_ready rises.
REQ-042 ap_rst asserted in the 2nd RUN cycle:
- The next cycle shows all outputs at reset values.
- After release, requester 0 wins against req_valid = 4'b1001.
